// File: rtl/macs_seq.sv
// macs_seq: sequencer for the 4-lane MAC array.
// Builds one 4-lane group of a dot product, acc = E +/- sum(a_k * b_k) mod 2^16 per lane.
// It streams N operand beats in and issues one MAC operation per beat.
// Each MAC result is fed back as c for the next term.
// The finished group is emitted on a valid/ready output.
//
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   start, len, sub, init_c          group request (sampled in IDLE only)
//   op_valid, op_ready, op_a, op_b   operand beat stream
//   mac_a/b/c, mac_mode, mac_signal  operand/control drive to the MAC
//   mac_en, mac_result, mac_done     MAC handshake
//   out_valid, out_ready, out_data   final group output
//   busy                             high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | op_ready high, waiting for an operand beat
// ISSUE | mac_en pulse for the captured beat
// WAIT  | waiting for mac_done, then fold result into acc
// OUT   | out_valid high with acc until out_ready

module macs_seq #(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sub,
    input  logic [63:0]      init_c,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [63:0]      op_b,
    output logic [31:0]      mac_a,
    output logic [63:0]      mac_b,
    output logic [63:0]      mac_c,
    output logic             mac_mode,
    output logic             mac_signal,
    output logic             mac_en,
    input  logic [63:0]      mac_result,
    input  logic             mac_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [LEN_W-1:0] k_inc;
    logic             sub_q, sub_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      a_q, a_d;
    logic [63:0]      b_q, b_d;
    logic             op_ready_q, op_ready_d;
    logic             mac_en_q, mac_en_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        k_d     = k_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        k_inc   = k_q + LEN_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    sub_d   = sub;
                    acc_d   = init_c;
                    k_d     = '0;
                    state_d = (len == '0) ? S_OUT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (op_valid && op_ready_q) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A done coinciding with en is not taken here; only a done
                // still high in WAIT completes the term.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    acc_d   = mac_result;
                    k_d     = k_inc;
                    state_d = (k_inc == len_q) ? S_OUT : S_LOAD;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered: decoded from the next state so
        // they rise in the very cycle the state is entered.
        op_ready_d  = (state_d == S_LOAD);
        mac_en_d    = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            k_q         <= '0;
            sub_q       <= 1'b0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_ready_q  <= 1'b0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            k_q         <= k_d;
            sub_q       <= sub_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_ready_q  <= op_ready_d;
            mac_en_q    <= mac_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign op_ready   = op_ready_q;
    assign mac_a      = a_q;
    assign mac_b      = b_q;
    assign mac_c      = acc_q;
    assign mac_mode   = 1'b0;
    assign mac_signal = sub_q;
    assign mac_en     = mac_en_q;
    assign out_valid  = out_valid_q;
    assign out_data   = acc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_macs_seq.sv
module tb_macs_seq;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             sub;
    logic [63:0]      init_c;
    logic             op_valid;
    logic             op_ready;
    logic [31:0]      op_a;
    logic [63:0]      op_b;
    logic [31:0]      mac_a;
    logic [63:0]      mac_b;
    logic [63:0]      mac_c;
    logic             mac_mode;
    logic             mac_signal;
    logic             mac_en;
    logic [63:0]      mac_result;
    logic             mac_done;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             busy;

    always #5 clk = ~clk;

    macs_seq #(.LEN_W(LEN_W)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .len        (len),
        .sub        (sub),
        .init_c     (init_c),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_mode   (mac_mode),
        .mac_signal (mac_signal),
        .mac_en     (mac_en),
        .mac_result (mac_result),
        .mac_done   (mac_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          en_cnt  = 0;
    int          mac_lat = 0;
    logic [63:0] cur_init = '0;
    logic        cur_sub  = 1'b0;
    logic [31:0] bq_a[$];
    logic [63:0] bq_b[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One MAC operation per lane: c +/- a*b, 16-bit wrap.
    function automatic logic [63:0] mac_ref(input logic [31:0] a, input logic [63:0] b,
                                            input logic [63:0] c, input logic s);
        logic [63:0] r;
        int unsigned p;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            p = 32'(a[8*i +: 8]) * 32'(b[16*i +: 16]);
            r[16*i +: 16] = s ? 16'(32'(c[16*i +: 16]) - p) : 16'(32'(c[16*i +: 16]) + p);
        end
        return r;
    endfunction

    // Whole group: E +/- (sum of products), reduced mod 2^16 per lane at the end.
    function automatic logic [63:0] group_ref(input logic [63:0] e, input logic s);
        logic [63:0]    r;
        longint         sum;
        longint         v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            sum = 0;
            for (int j = 0; j < bq_a.size(); j++)
                sum += longint'(bq_a[j][8*i +: 8]) * longint'(bq_b[j][16*i +: 16]);
            v = s ? (longint'(e[16*i +: 16]) - sum) : (longint'(e[16*i +: 16]) + sum);
            r[16*i +: 16] = v[15:0];
        end
        return r;
    endfunction

    // Behavioural MAC responder.
    initial begin : mac_model
        int          tidx;
        int          lat;
        logic [63:0] last_res;
        logic [31:0] ca;
        logic [63:0] cb, cc, res;
        tidx = 0;
        last_res = '0;
        mac_done = 1'b0;
        mac_result = '0;
        forever begin
            @(negedge clk);
            if (!busy) tidx = 0;
            if (mac_en) begin
                ca = mac_a;
                cb = mac_b;
                cc = mac_c;
                chk("mac_c_chain", cc, (tidx == 0) ? cur_init : last_res);
                chk("mac_signal", 64'(mac_signal), 64'(cur_sub));
                chk("mac_mode", 64'(mac_mode), 64'd0);
                res = mac_ref(ca, cb, cc, mac_signal);
                en_cnt++;
                lat = (mac_lat > 0) ? mac_lat : int'($urandom_range(1, 4));
                repeat (lat) @(negedge clk);
                if (busy) begin
                    chk("mac_hold_c", mac_c, cc);
                    chk("mac_hold_ab", {mac_a, mac_b[31:0]}, {ca, cb[31:0]});
                    chk("mac_en_pulse", 64'(mac_en), 64'd0);
                end
                mac_done = 1'b1;
                mac_result = res;
                @(negedge clk);
                mac_done = 1'b0;
                mac_result = $urandom();
                last_res = res;
                tidx++;
            end
        end
    end

    task automatic run_group(input int n, input logic sb, input logic [63:0] e, input int gap,
                             input bit fixed, input logic [31:0] fa, input logic [63:0] fb,
                             input bit poke, input int hold, output logic [63:0] got);
        logic [63:0] exp;
        int          en0;
        int          t;
        int          g;
        got = '0;
        bq_a.delete();
        bq_b.delete();
        for (int j = 0; j < n; j++) begin
            bq_a.push_back(fixed ? fa : $urandom());
            bq_b.push_back(fixed ? fb : {$urandom(), $urandom()});
        end
        exp = group_ref(e, sb);
        cur_init = e;
        cur_sub = sb;
        en0 = en_cnt;
        @(negedge clk);
        start = 1'b1;
        len = LEN_W'(n);
        sub = sb;
        init_c = e;
        @(negedge clk);
        start = 1'b0;
        len = LEN_W'($urandom());
        sub = ~sb;
        init_c = {$urandom(), $urandom()};
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int j = 0; j < n; j++) begin
            g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
            for (int q = 0; q < g; q++) begin
                start = poke && ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            start = 1'b0;
            op_valid = 1'b1;
            op_a = bq_a[j];
            op_b = bq_b[j];
            t = 0;
            while (!op_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                chk("op_ready_timeout", 64'd0, 64'd1);
                op_valid = 1'b0;
                return;
            end
            start = poke;
            @(negedge clk);
            start = 1'b0;
            op_valid = 1'b0;
            op_a = $urandom();
            op_b = {$urandom(), $urandom()};
            chk("op_ready_drop", 64'(op_ready), 64'd0);
        end
        t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        got = out_data;
        chk("en_count", 64'(en_cnt - en0), 64'(n));
        for (int h = 0; h < hold; h++) begin
            chk("out_data", out_data, exp);
            chk("out_valid_hold", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        start = poke;
        len = LEN_W'($urandom());
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk("out_valid_drop", 64'(out_valid), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
        @(negedge clk);
        chk("idle_after_out", 64'(busy), 64'd0);
    endtask

    initial begin : main
        logic [63:0] got;
        int          t;
        rstn = 1'b0;
        start = 1'b0;
        len = '0;
        sub = 1'b0;
        init_c = '0;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_mac_en", 64'(mac_en), 64'd0);
        chk("rst_acc", out_data, 64'd0);

        // len = 0: init passes straight through, no MAC activity
        run_group(0, 1'b0, 64'h0004_0003_0002_0001, 0, 1'b1, '0, '0, 1'b0, 5, got);
        chk("len0_const", got, 64'h0004_0003_0002_0001);

        mac_lat = 2;
        run_group(3, 1'b0, 64'd0, 0, 1'b1, 32'h0403_0201, 64'h0001_0001_0001_0001, 1'b0, 2, got);
        chk("len3_const", got, 64'h000C_0009_0006_0003);

        run_group(2, 1'b1, 64'd0, 1, 1'b1, 32'h0101_0101, 64'h0005_0005_0005_0005, 1'b0, 2, got);
        chk("sub_wrap_const", got, 64'hFFF6_FFF6_FFF6_FFF6);

        mac_lat = 0;
        run_group(4, 1'b0, {$urandom(), $urandom()}, 3, 1'b0, '0, '0, 1'b0, 1, got);
        run_group(3, 1'b1, {$urandom(), $urandom()}, 2, 1'b0, '0, '0, 1'b1, 2, got);

        // Reset while waiting on the MAC; its late done must be ignored.
        mac_lat = 4;
        cur_init = {$urandom(), $urandom()};
        cur_sub = 1'b0;
        @(negedge clk);
        start = 1'b1;
        len = LEN_W'(2);
        sub = 1'b0;
        init_c = cur_init;
        @(negedge clk);
        start = 1'b0;
        op_valid = 1'b1;
        op_a = $urandom();
        op_b = {$urandom(), $urandom()};
        t = 0;
        while (!op_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        op_valid = 1'b0;
        t = 0;
        while (!mac_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rstw_saw_en", 64'(mac_en), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_out_valid", 64'(out_valid), 64'd0);
        chk("rstw_acc", out_data, 64'd0);
        chk("rstw_op_ready", 64'(op_ready), 64'd0);
        mac_lat = 0;

        for (int r = 0; r < 8; r++) begin
            run_group(int'($urandom_range(1, 6)), 1'($urandom()), {$urandom(), $urandom()}, -1,
                      1'b0, '0, '0, 1'($urandom()), int'($urandom_range(1, 3)), got);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/macs_seq.md
Name: macs_seq

Overview:
- Initiator/sequencer for the 4-lane MAC array, which is a responder with an en/done handshake.
- Computes one 4-lane group of an Frodo-style dot product: acc = E ± Σ_{k<N} a_k·b_k (mod 2^16 per lane).
- Streams N operand beats in, issues one MAC operation per beat, and feeds each result back as the next c.
- Emits the final 64-bit group through a valid/ready output.

Parameters:
- LEN_W, 11, width of term-count input (N up to 2^LEN_W−1; covers 1344).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  LEN_W  number of terms N, sampled with start
- sub  in  1  0 = accumulate +a·b, 1 = accumulate −a·b; sampled with start
- init_c  in  64  initial lanes E (lane i = bits 16i+15:16i), sampled with start
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted when op_valid & op_ready
- op_a  in  32  four 8-bit a lanes (lane i = bits 8i+7:8i)
- op_b  in  64  four 16-bit b lanes
- mac_a  out  32  to MAC a_0..a_3
- mac_b  out  64  to MAC b_0..b_3
- mac_c  out  64  to MAC c_0..c_3
- mac_mode  out  1  to MAC mode; constant 0 (multiply-add)
- mac_signal  out  1  to MAC signal; equals latched sub
- mac_en  out  1  to MAC en; one-cycle pulse per issued term
- mac_result  in  64  MAC result
- mac_done  in  1  MAC completion pulse
- out_valid  out  1  final group valid
- out_ready  in  1  consumer ready
- out_data  out  64  final accumulated lanes
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn=0 at posedge, any state): state=IDLE and k=0. acc, op regs, sub latch, mac_en, op_ready, out_valid and busy all reset to 0. A reset mid-operation abandons the group; any later mac_done is ignored in IDLE.
- State IDLE: if start=1, latch len, sub and init_c into acc, set k=0, busy=1. Next state is OUT if len==0 (out_data=init_c), otherwise LOAD. While busy, start is ignored.
- State LOAD: op_ready=1 (registered, asserted the cycle the state is entered). On op_valid & op_ready, capture op_a into a_reg and op_b into b_reg; next state ISSUE. op_ready=0 in all other states.
- State ISSUE: mac_en=1 for exactly this cycle; next state WAIT.
- State WAIT: mac_en=0.
  - On mac_done=1: acc←mac_result, k←k+1. If k+1==len go to OUT, else go to LOAD.
  - mac_done arriving in the same cycle as mac_en (ISSUE) is legal and is treated as completion in WAIT's next cycle only if still high. The MAC's done is required to be at least 1 cycle after en.
- MAC drive: mac_a=a_reg, mac_b=b_reg, mac_c=acc, mac_mode=0, mac_signal=sub_latched. All are held stable from ISSUE through the done cycle. The negation of a when signal=1 is performed by the MAC, not here.
- State OUT: out_valid=1, out_data=acc, held stable until out_ready.
  - On out_valid & out_ready: out_valid drops next cycle, busy=0, state IDLE.
  - start in the same cycle as the accepting handshake is ignored; the next start is accepted in IDLE.
- Arithmetic: per-lane 16-bit wrap-around, no saturation; no lane carries between lanes.
- Minimum throughput: 3 cycles + MAC latency per term (LOAD, ISSUE, WAIT≥1).
- op_valid outside LOAD: beat not consumed (op_ready=0); source must hold.

Test Plan:
- Reset mid-WAIT, then mac_done pulse → stays IDLE; busy=0; out_valid=0; acc=0.
- len=0, init_c=64'h0004_0003_0002_0001, start → out_valid with out_data=64'h0004_0003_0002_0001; no mac_en pulse. out_ready held low 5 cycles → data stable; then accepted and busy=0.
- len=3, sub=0, init_c=0, each beat op_a=32'h04030201, op_b=64'h0001_0001_0001_0001, model MAC (result=c+a·b, done 2 cycles after en) → exactly 3 mac_en pulses; out_data=64'h000C_0009_0006_0003.
- sub=1, len=2, init_c lanes=16'h0000, op_a lanes=8'h01, op_b lanes=16'h0005 → every lane=16'hFFF6 (wrap); mac_signal=1 throughout.
- op_valid throttled (1 beat every 4 cycles), len=4 → op_ready only in LOAD; beats consumed in order. mac_c for term k equals the result of term k−1.
- start pulsed while busy and during the OUT handshake → ignored; len/init_c latches unchanged; result matches the original request.
